dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_if.sv | 8 +
 rtl/dmem_responder.sv | 61 ++++++
 tb/tb_dmem_responder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: core-side request/response bus for the data memory responder.
interface dmem_responder_if;
    logic        req, MemRead, MemWrite;
    logic [31:0] Address, WriteData, ReadData;
    logic        ack, err, busy;
    modport master(output req, MemRead, MemWrite, Address, WriteData, input ReadData, ack, err, busy);
    modport slave(input req, MemRead, MemWrite, Address, WriteData, output ReadData, ack, err, busy);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data memory with fixed response latency and error checking.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input logic             clock,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_d;
    logic [3:0] cnt, cnt_d;
    logic [31:0] mem [DEPTH];
    logic [31:0] addr_q, wdata_q, addr_s, wdata_s, rdata;
    logic rd_q, wr_q, rd_s, wr_s, accept, enter, bad, err_q;
    logic [AW-1:0] idx;
    // With LATENCY=1 the RESP entry is the accepting edge, so the live inputs are used there.
    always_comb begin
        accept  = state == IDLE && bus.req;
        enter   = (accept && LATENCY == 1) || (state == WAIT && cnt == 4'd1);
        state_d = enter ? RESP : accept ? WAIT : state == RESP ? IDLE : state;
        cnt_d   = accept ? 4'(LATENCY - 1) : state == WAIT ? cnt - 4'd1 : cnt;
        addr_s  = state == IDLE ? bus.Address : addr_q;
        wdata_s = state == IDLE ? bus.WriteData : wdata_q;
        rd_s    = state == IDLE ? bus.MemRead : rd_q;
        wr_s    = state == IDLE ? bus.MemWrite : wr_q;
        idx     = addr_s[AW+1:2];
        bad     = addr_s[1:0] != 2'b00 || addr_s >= 32'(4 * DEPTH) || rd_s == wr_s;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata   <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            err_q <= enter && bad;
            if (accept) begin
                addr_q  <= bus.Address;
                wdata_q <= bus.WriteData;
                rd_q    <= bus.MemRead;
                wr_q    <= bus.MemWrite;
            end
            if (enter && bad) rdata <= '0;
            else if (enter && rd_s) rdata <= mem[idx];
            if (enter && !bad && wr_s) mem[idx] <= wdata_s;
        end
    end
    assign bus.ReadData = rdata;
    assign bus.ack      = state == RESP;
    assign bus.err      = err_q;
    assign bus.busy     = state != IDLE;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder with LATENCY=2 and LATENCY=1 instances.
module tb_dmem_responder;
    logic clock = 1'b0, reset = 1'b1;
    logic req = 1'b0, sel = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    int n_tests = 0, n_fail = 0;
    int lat;
    logic [31:0] q;
    logic e;
    always #5 clock = ~clock;
    dmem_responder_if ia();
    dmem_responder_if ib();
    assign ia.req = req && !sel;
    assign ia.MemRead = rd;
    assign ia.MemWrite = wr;
    assign ia.Address = addr;
    assign ia.WriteData = wdata;
    assign ib.req = req && sel;
    assign ib.MemRead = rd;
    assign ib.MemWrite = wr;
    assign ib.Address = addr;
    assign ib.WriteData = wdata;
    dmem_responder #(.DEPTH(256), .LATENCY(2)) u_a (.clock(clock), .reset(reset), .bus(ia));
    dmem_responder #(.DEPTH(256), .LATENCY(1)) u_b (.clock(clock), .reset(reset), .bus(ib));
    logic ack_s, err_s;
    logic [31:0] rdata_s;
    assign ack_s = sel ? ib.ack : ia.ack;
    assign err_s = sel ? ib.err : ia.err;
    assign rdata_s = sel ? ib.ReadData : ia.ReadData;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues one request, waits for ack (bounded), captures outputs in the ack cycle, then returns to IDLE.
    task automatic xfer(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int l, output logic [31:0] rq, output logic re);
        rd = r; wr = w; addr = a; wdata = d; req = 1'b1;
        tick();
        req = 1'b0;
        l = 1;
        while (!ack_s && l < 20) begin
            tick();
            l++;
        end
        chk("ack_seen", 32'(ack_s), 32'd1);
        rq = rdata_s;
        re = err_s;
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy_a", 32'(ia.busy), 0);
        chk("rst_ack_a", 32'(ia.ack), 0);
        chk("rst_err_a", 32'(ia.err), 0);
        chk("rst_rdata_a", ia.ReadData, 0);
        chk("rst_busy_b", 32'(ib.busy), 0);
        chk("rst_rdata_b", ib.ReadData, 0);
        reset = 1'b0;
        tick();
        xfer(0, 1, 32'h10, 32'hDEADBEEF, lat, q, e);
        chk("wr10_lat", 32'(lat), 2);
        chk("wr10_err", 32'(e), 0);
        chk("wr10_rdata_hold", q, 0);
        xfer(1, 0, 32'h10, 32'h0, lat, q, e);
        chk("rd10_lat", 32'(lat), 2);
        chk("rd10_data", q, 32'hDEADBEEF);
        chk("rd10_err", 32'(e), 0);
        chk("idle_ack", 32'(ia.ack), 0);
        chk("idle_err", 32'(ia.err), 0);
        chk("idle_rdata_hold", ia.ReadData, 32'hDEADBEEF);
        xfer(1, 0, 32'h13, 32'h0, lat, q, e);
        chk("rd13_err", 32'(e), 1);
        chk("rd13_data", q, 0);
        xfer(1, 0, 32'h400, 32'h0, lat, q, e);
        chk("rd400_err", 32'(e), 1);
        chk("rd400_data", q, 0);
        xfer(0, 1, 32'h410, 32'h00000BAD, lat, q, e);
        chk("wr410_err", 32'(e), 1);
        xfer(0, 1, 32'h11, 32'h00001234, lat, q, e);
        chk("wr11_err", 32'(e), 1);
        xfer(1, 0, 32'h10, 32'h0, lat, q, e);
        chk("rd10_unchanged", q, 32'hDEADBEEF);
        xfer(1, 1, 32'h20, 32'h55, lat, q, e);
        chk("rdwr20_err", 32'(e), 1);
        xfer(1, 0, 32'h20, 32'h0, lat, q, e);
        chk("rd20_data", q, 0);
        chk("rd20_err", 32'(e), 0);
        xfer(0, 0, 32'h24, 32'h0, lat, q, e);
        chk("noop24_err", 32'(e), 1);
        for (int k = 0; k < 9; k++) xfer(0, 1, 32'h40 + 32'(4 * k), 32'h100 + 32'(k), lat, q, e);
        rd = 1'b1; wr = 1'b0; req = 1'b1;
        // Address changes every cycle; only the value present in IDLE cycles may be used.
        for (int k = 0; k < 9; k++) begin
            addr = 32'h40 + 32'(4 * k);
            tick();
            chk("stream_busy", 32'(ia.busy), 32'((k % 3) != 2));
            chk("stream_ack", 32'(ia.ack), 32'((k % 3) == 1));
            if (k % 3 == 1) chk("stream_data", ia.ReadData, 32'h100 + 32'(k - 1));
        end
        req = 1'b0;
        tick();
        rd = 1'b0; wr = 1'b1; addr = 32'h8; wdata = 32'h77; req = 1'b1;
        tick();
        req = 1'b0;
        chk("abort_wait_busy", 32'(ia.busy), 1);
        chk("abort_wait_ack", 32'(ia.ack), 0);
        reset = 1'b1;
        tick();
        chk("abort_ack", 32'(ia.ack), 0);
        chk("abort_busy", 32'(ia.busy), 0);
        chk("abort_err", 32'(ia.err), 0);
        chk("abort_rdata", ia.ReadData, 0);
        rd = 1'b1; wr = 1'b0; addr = 32'h10; req = 1'b1;
        tick();
        chk("req_in_reset_busy", 32'(ia.busy), 0);
        reset = 1'b0; req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_reset_ack", 32'(ia.ack), 0);
            chk("post_reset_busy", 32'(ia.busy), 0);
        end
        xfer(1, 0, 32'h8, 32'h0, lat, q, e);
        chk("rd8_after_abort", q, 0);
        xfer(1, 0, 32'h10, 32'h0, lat, q, e);
        chk("rd10_cleared", q, 0);
        sel = 1'b1;
        xfer(0, 1, 32'h4, 32'hCAFEF00D, lat, q, e);
        chk("l1_wr_lat", 32'(lat), 1);
        chk("l1_wr_err", 32'(e), 0);
        xfer(1, 0, 32'h4, 32'h0, lat, q, e);
        chk("l1_rd_lat", 32'(lat), 1);
        chk("l1_rd_data", q, 32'hCAFEF00D);
        chk("l1_rd_err", 32'(e), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
